// File: rtl/regfile_mp_clr.sv
// rtl/regfile_mp_clr.sv - multi-read-port register file with a sequential clear engine
module regfile_mp_clr #(
    parameter int               WIDTH    = 32,
    parameter int               ADDR_W   = 5,
    parameter int               NREAD    = 2,
    parameter int               ZERO_REG = 1,
    parameter int               BYPASS   = 1,
    parameter logic [WIDTH-1:0] CLR_VAL  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [NREAD*ADDR_W-1:0] raddr,
    output logic [NREAD*WIDTH-1:0]  rdata,
    input  logic                    clr_req,
    output logic                    clr_busy,
    output logic                    clr_done,
    output logic                    wr_blocked
);
    localparam int              DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'((ZERO_REG != 0) ? 1 : 0);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [WIDTH-1:0]  regs [DEPTH];
    logic              wr_ok;

    assign wr_ok      = we && !clr_busy && !((ZERO_REG != 0) && (waddr == '0));
    assign wr_blocked = we & clr_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= FIRST;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        cnt      <= FIRST;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    // leave before incrementing so the counter never wraps past LAST
                    if (cnt == LAST) begin
                        state    <= DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    cnt      <= FIRST;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= FIRST;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    // user writes and sweep writes are exclusive: wr_ok requires !clr_busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= ((ZERO_REG != 0) && (i == 0)) ? '0 : CLR_VAL;
        end else begin
            if (wr_ok)
                regs[waddr] <= wdata;
            if (state == CLEAR)
                regs[cnt] <= CLR_VAL;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [WIDTH-1:0]  rd;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = regs[ra];
            if ((ZERO_REG != 0) && (ra == '0))
                rd = '0;
            else if ((BYPASS != 0) && wr_ok && (waddr == ra))
                rd = wdata;
        end

        assign rdata[k*WIDTH +: WIDTH] = rd;
    end
endmodule

// File: tb/tb_regfile_mp_clr.sv
// tb/tb_regfile_mp_clr.sv - self-checking bench for regfile_mp_clr (default and 64-bit/no-zero configs)
module tb_regfile_mp_clr;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, we, clr_req, clr_busy, clr_done, wr_blocked;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;

    logic         p_we, p_clr_req, p_busy, p_done, p_blk;
    logic [3:0]   p_waddr;
    logic [63:0]  p_wdata;
    logic [11:0]  p_raddr;
    logic [191:0] p_rdata;

    regfile_mp_clr dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .clr_req(clr_req), .clr_busy(clr_busy),
        .clr_done(clr_done), .wr_blocked(wr_blocked)
    );

    regfile_mp_clr #(.WIDTH(64), .ADDR_W(4), .NREAD(3), .ZERO_REG(0)) dut_p (
        .clk(clk), .rst_n(rst_n), .we(p_we), .waddr(p_waddr), .wdata(p_wdata),
        .raddr(p_raddr), .rdata(p_rdata), .clr_req(p_clr_req), .clr_busy(p_busy),
        .clr_done(p_done), .wr_blocked(p_blk)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct { string name; logic [63:0] exp; } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra0, ra1;
        logic [31:0] e0, e1;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic sb_push(input string name, input logic [63:0] e);
        exp_t x;
        x.name = name;
        x.exp  = e;
        sb.push_back(x);
    endtask

    task automatic sb_pop(input logic [63:0] act);
        exp_t x;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL sb_empty: got 0x%0h expected a queued value", act);
        end else begin
            x = sb.pop_front();
            check(x.name, act, x.exp);
        end
    endtask

    task automatic pulse_clr();
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
    endtask

    // called on the first busy negedge; returns busy-cycle count and cycle index of clr_done
    task automatic run_sweep(input bit hooks, output int nb, output int done_at);
        nb = 0;
        done_at = 0;
        for (int c = 1; c <= 40; c++) begin
            we = 1'b0;
            if (clr_busy) nb++;
            if (clr_done && done_at == 0) done_at = c;
            if (hooks && clr_busy && nb == 10) begin
                raddr = {5'd20, 5'd9};
                #1;
                check("mid_r9", {32'd0, rdata[31:0]}, 64'd0);
                check("mid_r20", {32'd0, rdata[63:32]}, 64'd20);
                raddr = {5'd10, 5'd10};
                #1;
                check("mid_r10_unswept", {32'd0, rdata[31:0]}, 64'd10);
            end
            if (hooks && clr_busy && nb == 12) begin
                we = 1'b1; waddr = 5'd31; wdata = 32'h55;
                #1;
                check("wr_blocked", {63'd0, wr_blocked}, 64'd1);
            end
            if (done_at != 0) break;
            @(negedge clk);
        end
        we = 1'b0;
    endtask

    initial begin
        int nb, done_at, dcount;

        vecs[0] = '{1'b1, 5'd5, 32'h0000010E, 5'd1, 5'd0, 32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 32'h0000010E, 32'h0};
        vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 32'h0,        32'h0000010E};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd7, 32'hABCD0123, 5'd5, 5'd7, 32'h0000010E, 32'hABCD0123};
        vecs[5] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 32'hABCD0123, 32'hABCD0123};
        vecs[6] = '{1'b1, 5'd5, 32'h0000DEAD, 5'd5, 5'd5, 32'h0000DEAD, 32'h0000DEAD};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd31, 32'h0000DEAD, 32'h0};

        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; clr_req = 1'b0;
        p_we = 1'b0; p_waddr = '0; p_wdata = '0; p_raddr = '0; p_clr_req = 1'b0;
        repeat (2) @(negedge clk);
        raddr = {5'd31, 5'd5};
        #1;
        check("rst_busy", {63'd0, clr_busy}, 64'd0);
        check("rst_done", {63'd0, clr_done}, 64'd0);
        check("rst_rdata", rdata, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            raddr = {vecs[i].ra1, vecs[i].ra0};
            sb_push($sformatf("vec%0d_p0", i), {32'd0, vecs[i].e0});
            sb_push($sformatf("vec%0d_p1", i), {32'd0, vecs[i].e1});
            #1;
            sb_pop({32'd0, rdata[31:0]});
            sb_pop({32'd0, rdata[63:32]});
        end
        @(negedge clk);
        we = 1'b0;

        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = i;
            @(negedge clk);
        end
        we = 1'b0;
        raddr = {5'd31, 5'd20};
        #1;
        check("pre_r20", {32'd0, rdata[31:0]}, 64'd20);
        check("pre_r31", {32'd0, rdata[63:32]}, 64'd31);

        pulse_clr();
        run_sweep(1'b1, nb, done_at);
        check("sweep_busy_cycles", 64'(nb), 64'd31);
        check("sweep_done_cycle", 64'(done_at), 64'd32);
        @(negedge clk);
        check("done_one_cycle", {63'd0, clr_done}, 64'd0);
        for (int i = 0; i < 32; i++) begin
            raddr = {5'(31 - i), 5'(i)};
            sb_push($sformatf("post_r%0d", i), 64'd0);
            sb_push($sformatf("post_r%0d", 31 - i), 64'd0);
            #1;
            sb_pop({32'd0, rdata[31:0]});
            sb_pop({32'd0, rdata[63:32]});
        end

        @(negedge clk);
        we = 1'b1; waddr = 5'd30; wdata = 32'h30;
        @(negedge clk);
        we = 1'b0;
        pulse_clr();
        repeat (14) @(negedge clk);
        check("abort_busy_before", {63'd0, clr_busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        raddr = {5'd30, 5'd30};
        #1;
        check("abort_busy_drop", {63'd0, clr_busy}, 64'd0);
        check("abort_r30", {32'd0, rdata[31:0]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (clr_done || clr_busy) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'd0);
        pulse_clr();
        run_sweep(1'b0, nb, done_at);
        check("restart_busy_cycles", 64'(nb), 64'd31);
        check("restart_done_cycle", 64'(done_at), 64'd32);

        @(negedge clk);
        p_we = 1'b1; p_waddr = 4'd0; p_wdata = 64'h1122334455667788;
        p_raddr = {4'd15, 4'd0, 4'd0};
        #1;
        check("p_bypass_r0", p_rdata[63:0], 64'h1122334455667788);
        @(negedge clk);
        p_waddr = 4'd15; p_wdata = 64'hF0F0F0F0F0F0F0F0;
        @(negedge clk);
        p_we = 1'b0;
        #1;
        check("p_r0_writable", p_rdata[127:64], 64'h1122334455667788);
        check("p_r15", p_rdata[191:128], 64'hF0F0F0F0F0F0F0F0);
        p_clr_req = 1'b1;
        @(negedge clk);
        p_clr_req = 1'b0;
        nb = 0; done_at = 0;
        for (int c = 1; c <= 30; c++) begin
            if (p_busy) nb++;
            if (p_done && done_at == 0) done_at = c;
            if (done_at != 0) break;
            @(negedge clk);
        end
        check("p_sweep_busy_cycles", 64'(nb), 64'd16);
        check("p_sweep_done_cycle", 64'(done_at), 64'd17);
        #1;
        check("p_r0_cleared", p_rdata[63:0], 64'd0);
        check("p_r15_cleared", p_rdata[191:128], 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
